// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI mode encoding, FSM states and SS polarity helper
package spi_pkg;

    typedef enum logic [1:0] {
        SPI_MODE0 = 2'd0,
        SPI_MODE1 = 2'd1,
        SPI_MODE2 = 2'd2,
        SPI_MODE3 = 2'd3
    } spi_mode_e;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

    function automatic spi_mode_e spi_mode_of(input logic cpol, input logic cpha);
        return spi_mode_e'({cpol, cpha});
    endfunction

    function automatic logic ss_is_active(input logic ss, input logic active_low);
        return active_low ? ~ss : ss;
    endfunction

endpackage

// File: rtl/spi_input_sync.sv
// rtl/spi_input_sync.sv - multi-stage pin synchroniser with one extra edge-detect register
module spi_input_sync #(
    parameter int              WIDTH       = 3,
    parameter int              SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] prev
);

    logic [WIDTH-1:0] stages [SYNC_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stages[i] <= RESET_VAL;
            end
            prev <= RESET_VAL;
        end else begin
            stages[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stages[i] <= stages[i-1];
            end
            prev <= stages[SYNC_STAGES-1];
        end
    end

    assign sync = stages[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_mode_driver.sv
// rtl/spi_slave_mode_driver.sv - SPI slave, all four modes, multi-word frames, one-entry MISO buffer
module spi_slave_mode_driver
    import spi_pkg::*;
#(
    parameter logic SS_ACTIVE_LOW = 1'b1,
    parameter logic LSB_FIRST     = 1'b0,
    parameter int   NUM_DATA_BITS = 8,
    parameter logic CPOL          = 1'b0,
    parameter logic CPHA          = 1'b0,
    parameter int   SYNC_STAGES   = 2,
    parameter logic MISO_FILL     = 1'b1
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic                     miso_send_enable,
    input  logic [NUM_DATA_BITS-1:0] miso_data,
    input  logic                     miso_valid,
    output logic                     miso_ready,
    output logic                     bus_ready,
    output logic                     mosi_new_data,
    output logic [NUM_DATA_BITS-1:0] mosi_data,
    output logic                     frame_abort,
    output logic                     miso_underrun,
    input  logic                     ss_in,
    input  logic                     sclk_in,
    input  logic                     mosi_in,
    output logic                     miso_out,
    output logic                     miso_oe
);

    localparam int        CNT_W         = $clog2(NUM_DATA_BITS + 1);
    localparam spi_mode_e MODE          = spi_mode_of(CPOL, CPHA);
    localparam logic      SHIFT_ON_LEAD = (MODE == SPI_MODE1) || (MODE == SPI_MODE3);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_DATA_BITS - 1);
    localparam logic [NUM_DATA_BITS-1:0] FILL_WORD = {NUM_DATA_BITS{MISO_FILL}};

    logic [2:0] pin_sync;
    logic [2:0] pin_prev;
    logic [1:0] unused_prev;

    // Synchronisers reset to the idle pin levels so no false edge or SS is seen after reset.
    spi_input_sync #(
        .WIDTH      (3),
        .SYNC_STAGES(SYNC_STAGES),
        .RESET_VAL  ({SS_ACTIVE_LOW, CPOL, 1'b0})
    ) u_input_sync (
        .clk  (sys_clk),
        .rst_n(rst),
        .raw  ({ss_in, sclk_in, mosi_in}),
        .sync (pin_sync),
        .prev (pin_prev)
    );

    assign unused_prev = {pin_prev[2], pin_prev[0]};

    spi_state_e               state;
    logic                     send_en;
    logic [CNT_W-1:0]         bit_cnt;
    logic [NUM_DATA_BITS-1:0] rx_sr;
    logic [NUM_DATA_BITS-1:0] tx_sr;
    logic [NUM_DATA_BITS-1:0] buf_data;
    logic                     buf_full;
    logic                     load_pending;
    logic                     first_shift;

    logic ss_act, mosi_s, lead_edge, trail_edge, sample_edge, shift_edge;
    logic do_load, load_notify, tx_bit;
    logic [NUM_DATA_BITS-1:0] rx_next, tx_shifted, load_word;

    assign ss_act      = ss_is_active(pin_sync[2], SS_ACTIVE_LOW);
    assign mosi_s      = pin_sync[0];
    assign lead_edge   = (pin_prev[1] == CPOL) && (pin_sync[1] != CPOL);
    assign trail_edge  = (pin_prev[1] != CPOL) && (pin_sync[1] == CPOL);
    assign sample_edge = SHIFT_ON_LEAD ? trail_edge : lead_edge;
    assign shift_edge  = SHIFT_ON_LEAD ? lead_edge : trail_edge;

    assign rx_next    = LSB_FIRST ? {mosi_s, rx_sr[NUM_DATA_BITS-1:1]}
                                  : {rx_sr[NUM_DATA_BITS-2:0], mosi_s};
    assign tx_shifted = LSB_FIRST ? {1'b0, tx_sr[NUM_DATA_BITS-1:1]}
                                  : {tx_sr[NUM_DATA_BITS-2:0], 1'b0};
    assign tx_bit     = LSB_FIRST ? tx_sr[0] : tx_sr[NUM_DATA_BITS-1];
    assign load_word  = buf_full ? buf_data : FILL_WORD;

    // A TX word is loaded at frame start and on the first shift edge after a word boundary.
    assign do_load     = ((state == IDLE) && ss_act)
                       || ((state == ACTIVE) && ss_act && load_pending && shift_edge);
    assign load_notify = (state == IDLE) ? miso_send_enable : send_en;

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            send_en       <= 1'b0;
            bit_cnt       <= '0;
            rx_sr         <= '0;
            tx_sr         <= '0;
            buf_data      <= '0;
            buf_full      <= 1'b0;
            load_pending  <= 1'b0;
            first_shift   <= 1'b0;
            mosi_data     <= '0;
            mosi_new_data <= 1'b0;
            frame_abort   <= 1'b0;
            miso_underrun <= 1'b0;
        end else begin
            mosi_new_data <= 1'b0;
            frame_abort   <= 1'b0;
            miso_underrun <= 1'b0;

            if (miso_valid && !buf_full) begin
                buf_data <= miso_data;
                buf_full <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (ss_act) begin
                        state        <= ACTIVE;
                        send_en      <= miso_send_enable;
                        bit_cnt      <= '0;
                        load_pending <= 1'b0;
                        first_shift  <= SHIFT_ON_LEAD;
                    end
                end
                ACTIVE: begin
                    if (!ss_act) begin
                        state        <= IDLE;
                        bit_cnt      <= '0;
                        load_pending <= 1'b0;
                        if (bit_cnt != '0) begin
                            frame_abort <= 1'b1;
                            tx_sr       <= '0;
                        end
                    end else begin
                        if (sample_edge) begin
                            rx_sr <= rx_next;
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt       <= '0;
                                mosi_data     <= rx_next;
                                mosi_new_data <= 1'b1;
                                load_pending  <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                        // With CPHA=1 the first leading edge only presents bit 0 already in place.
                        if (shift_edge) begin
                            if (load_pending) begin
                                load_pending <= 1'b0;
                            end else if (first_shift) begin
                                first_shift <= 1'b0;
                            end else begin
                                tx_sr <= tx_shifted;
                            end
                        end
                    end
                end
            endcase

            if (do_load) begin
                tx_sr <= load_word;
                if (buf_full) begin
                    buf_full <= 1'b0;
                end else if (load_notify) begin
                    miso_underrun <= 1'b1;
                end
            end
        end
    end

    assign bus_ready  = (state == IDLE);
    assign miso_ready = ~buf_full;
    assign miso_oe    = (state == ACTIVE) && send_en;
    assign miso_out   = miso_oe ? tx_bit : MISO_FILL;

endmodule

// File: tb/tb_spi_slave_mode_driver.sv
// tb/tb_spi_slave_mode_driver.sv - scoreboard bench for spi_slave_mode_driver across modes 0-3
module tb_spi_slave_mode_driver;

    localparam int HALF     = 8;
    localparam int EV_RX    = 0;
    localparam int EV_ABORT = 1;
    localparam int EV_UNDR  = 2;

    typedef struct {
        int          inst;
        int          kind;
        logic [15:0] data;
    } ev_t;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  ss = 4'b1111;
    logic [3:0]  sclk = 4'b1100;
    logic [3:0]  mosi = 4'b0000;
    logic [3:0]  send_en = 4'b0000;
    logic [3:0]  mvalid = 4'b0000;
    logic [15:0] mdata0 = '0;
    logic [7:0]  mdata1 = '0, mdata2 = '0, mdata3 = '0;
    logic [3:0]  mready, bready, new_d, abort_p, undr, miso_out, miso_oe;
    logic [15:0] rx0;
    logic [7:0]  rx1, rx2, rx3;

    int          tests = 0;
    int          fails = 0;
    ev_t         exp_q[$];
    logic [15:0] got;

    always #5 sys_clk = ~sys_clk;

    spi_slave_mode_driver #(.SS_ACTIVE_LOW(1'b1), .LSB_FIRST(1'b0), .NUM_DATA_BITS(16),
        .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2), .MISO_FILL(1'b1)) u0 (
        .sys_clk(sys_clk), .rst(rst), .miso_send_enable(send_en[0]), .miso_data(mdata0),
        .miso_valid(mvalid[0]), .miso_ready(mready[0]), .bus_ready(bready[0]),
        .mosi_new_data(new_d[0]), .mosi_data(rx0), .frame_abort(abort_p[0]),
        .miso_underrun(undr[0]), .ss_in(ss[0]), .sclk_in(sclk[0]), .mosi_in(mosi[0]),
        .miso_out(miso_out[0]), .miso_oe(miso_oe[0]));

    spi_slave_mode_driver #(.SS_ACTIVE_LOW(1'b1), .LSB_FIRST(1'b1), .NUM_DATA_BITS(8),
        .CPOL(1'b0), .CPHA(1'b1), .SYNC_STAGES(2), .MISO_FILL(1'b1)) u1 (
        .sys_clk(sys_clk), .rst(rst), .miso_send_enable(send_en[1]), .miso_data(mdata1),
        .miso_valid(mvalid[1]), .miso_ready(mready[1]), .bus_ready(bready[1]),
        .mosi_new_data(new_d[1]), .mosi_data(rx1), .frame_abort(abort_p[1]),
        .miso_underrun(undr[1]), .ss_in(ss[1]), .sclk_in(sclk[1]), .mosi_in(mosi[1]),
        .miso_out(miso_out[1]), .miso_oe(miso_oe[1]));

    spi_slave_mode_driver #(.SS_ACTIVE_LOW(1'b1), .LSB_FIRST(1'b1), .NUM_DATA_BITS(8),
        .CPOL(1'b1), .CPHA(1'b0), .SYNC_STAGES(2), .MISO_FILL(1'b1)) u2 (
        .sys_clk(sys_clk), .rst(rst), .miso_send_enable(send_en[2]), .miso_data(mdata2),
        .miso_valid(mvalid[2]), .miso_ready(mready[2]), .bus_ready(bready[2]),
        .mosi_new_data(new_d[2]), .mosi_data(rx2), .frame_abort(abort_p[2]),
        .miso_underrun(undr[2]), .ss_in(ss[2]), .sclk_in(sclk[2]), .mosi_in(mosi[2]),
        .miso_out(miso_out[2]), .miso_oe(miso_oe[2]));

    spi_slave_mode_driver #(.SS_ACTIVE_LOW(1'b1), .LSB_FIRST(1'b1), .NUM_DATA_BITS(8),
        .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(3), .MISO_FILL(1'b1)) u3 (
        .sys_clk(sys_clk), .rst(rst), .miso_send_enable(send_en[3]), .miso_data(mdata3),
        .miso_valid(mvalid[3]), .miso_ready(mready[3]), .bus_ready(bready[3]),
        .mosi_new_data(new_d[3]), .mosi_data(rx3), .frame_abort(abort_p[3]),
        .miso_underrun(undr[3]), .ss_in(ss[3]), .sclk_in(sclk[3]), .mosi_in(mosi[3]),
        .miso_out(miso_out[3]), .miso_oe(miso_oe[3]));

    function automatic logic [15:0] rx_of(input int i);
        case (i)
            0:       return rx0;
            1:       return {8'h00, rx1};
            2:       return {8'h00, rx2};
            default: return {8'h00, rx3};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        tests++;
        if (actual !== required) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, actual, required);
        end
    endtask

    task automatic expect_ev(input int inst, input int kind, input logic [15:0] data);
        exp_q.push_back('{inst, kind, data});
    endtask

    task automatic check_ev(input int inst, input int kind, input logic [15:0] data);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected: got inst %0d kind %0d data %h, required no event", inst, kind, data);
        end else begin
            e = exp_q.pop_front();
            if (e.inst != inst || e.kind != kind || e.data !== data) begin
                fails++;
                $display("FAIL sb_event: got inst %0d kind %0d data %h, required inst %0d kind %0d data %h",
                         inst, kind, data, e.inst, e.kind, e.data);
            end
        end
    endtask

    // Monitor: every output pulse from any instance must match the next expected event.
    initial begin
        forever begin
            @(negedge sys_clk);
            for (int i = 0; i < 4; i++) begin
                if (abort_p[i]) check_ev(i, EV_ABORT, 16'h0000);
                if (new_d[i])   check_ev(i, EV_RX, rx_of(i));
                if (undr[i])    check_ev(i, EV_UNDR, 16'h0000);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic push_buf(input int idx, input logic [15:0] d);
        int n;
        n = 0;
        while (!mready[idx] && n < 400) begin
            @(negedge sys_clk);
            n++;
        end
        check($sformatf("buf_ready_wait_%0d", idx), mready[idx], 1'b1);
        case (idx)
            0:       mdata0 = d;
            1:       mdata1 = d[7:0];
            2:       mdata2 = d[7:0];
            default: mdata3 = d[7:0];
        endcase
        mvalid[idx] = 1'b1;
        @(negedge sys_clk);
        mvalid[idx] = 1'b0;
    endtask

    task automatic master_word(input int idx, input int width, input int nsend,
                               input logic [15:0] tx, output logic [15:0] rx_got);
        logic cpol, cpha, lsb;
        cpol = (idx >= 2);
        cpha = (idx == 1 || idx == 3);
        lsb  = (idx != 0);
        rx_got = '0;
        for (int i = 0; i < nsend; i++) begin
            int b;
            b = lsb ? i : width - 1 - i;
            if (!cpha) mosi[idx] = tx[b];
            wait_cyc(HALF);
            sclk[idx] = ~cpol;
            if (cpha) mosi[idx] = tx[b];
            else      rx_got[b] = miso_out[idx];
            wait_cyc(HALF);
            sclk[idx] = cpol;
            if (cpha) rx_got[b] = miso_out[idx];
        end
    endtask

    task automatic ss_off(input int idx);
        wait_cyc(HALF);
        ss[idx] = 1'b1;
        wait_cyc(2 * HALF);
    endtask

    initial begin
        wait_cyc(3);
        check("reset_bus_ready", bready[0], 1'b1);
        check("reset_miso_ready", mready[0], 1'b1);
        check("reset_mosi_data", rx0, 16'h0000);
        check("reset_miso_out", miso_out[0], 1'b1);
        check("reset_miso_oe", miso_oe[0], 1'b0);
        rst = 1'b1;
        wait_cyc(4);

        // Mode 0, 16-bit MSB first; the final trailing edge starts an empty word -> underrun.
        push_buf(0, 16'h0cf7);
        send_en[0] = 1'b1;
        check("m0_oe_before", miso_oe[0], 1'b0);
        expect_ev(0, EV_RX, 16'h4ac5);
        expect_ev(0, EV_UNDR, 16'h0000);
        ss[0] = 1'b0;
        master_word(0, 16, 16, 16'h4ac5, got);
        check("m0_oe_during", miso_oe[0], 1'b1);
        ss_off(0);
        check("m0_miso", got, 16'h0cf7);
        check("m0_oe_after", miso_oe[0], 1'b0);

        // Modes 1..3, 8-bit LSB first.
        for (int m = 1; m < 4; m++) begin
            push_buf(m, 16'h003c);
            send_en[m] = 1'b1;
            expect_ev(m, EV_RX, 16'h00a5);
            if (m == 2) expect_ev(m, EV_UNDR, 16'h0000);
            ss[m] = 1'b0;
            master_word(m, 8, 8, 16'h00a5, got);
            ss_off(m);
            check($sformatf("mode%0d_miso", m), got, 16'h003c);
        end

        // Multi-word frame on mode 1 with refills after each miso_ready rise.
        push_buf(1, 16'h00a1);
        expect_ev(1, EV_RX, 16'h0011);
        expect_ev(1, EV_RX, 16'h0022);
        expect_ev(1, EV_RX, 16'h0033);
        fork
            begin
                ss[1] = 1'b0;
                master_word(1, 8, 8, 16'h0011, got);
                check("mw_miso0", got, 16'h00a1);
                master_word(1, 8, 8, 16'h0022, got);
                check("mw_miso1", got, 16'h00a2);
                master_word(1, 8, 8, 16'h0033, got);
                check("mw_miso2", got, 16'h00a3);
                ss_off(1);
            end
            begin
                push_buf(1, 16'h00a2);
                push_buf(1, 16'h00a3);
            end
        join

        // Underrun on mode 3: two words, one buffered.
        push_buf(3, 16'h005a);
        expect_ev(3, EV_RX, 16'h000f);
        expect_ev(3, EV_UNDR, 16'h0000);
        expect_ev(3, EV_RX, 16'h00f0);
        ss[3] = 1'b0;
        master_word(3, 8, 8, 16'h000f, got);
        check("ur_miso0", got, 16'h005a);
        master_word(3, 8, 8, 16'h00f0, got);
        check("ur_miso1", got, 16'h00ff);
        ss_off(3);

        // Abort after 5 of 16 bits, then a full frame.
        send_en[0] = 1'b0;
        expect_ev(0, EV_ABORT, 16'h0000);
        ss[0] = 1'b0;
        master_word(0, 16, 5, 16'h16fb, got);
        ss_off(0);
        check("abort_mosi_data_kept", rx0, 16'h4ac5);
        check("abort_bus_ready", bready[0], 1'b1);
        expect_ev(0, EV_RX, 16'h35d9);
        ss[0] = 1'b0;
        master_word(0, 16, 16, 16'h35d9, got);
        ss_off(0);
        check("post_abort_miso_fill", got, 16'hffff);

        // Reset mid-word.
        ss[0] = 1'b0;
        master_word(0, 16, 7, 16'h1234, got);
        rst = 1'b0;
        ss[0] = 1'b1;
        wait_cyc(3);
        check("rst_bus_ready", bready[0], 1'b1);
        check("rst_miso_ready", mready[0], 1'b1);
        check("rst_mosi_data", rx0, 16'h0000);
        check("rst_miso_out", miso_out[0], 1'b1);
        check("rst_miso_oe", miso_oe[0], 1'b0);
        rst = 1'b1;
        wait_cyc(4);
        expect_ev(0, EV_RX, 16'h9e21);
        ss[0] = 1'b0;
        master_word(0, 16, 16, 16'h9e21, got);
        check("rst_frame_oe_disabled", miso_oe[0], 1'b0);
        check("rst_frame_bus_busy", bready[0], 1'b0);
        ss_off(0);
        check("rst_frame_miso_fill", got, 16'hffff);

        wait_cyc(20);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
